// File: rtl/vtg_1080p.sv
// Raster timing generator for the HDMI path. Advances one pixel per ce cycle through a
// 2200x1125 raster and emits registered de/hsync/vsync, x/y, and line/frame start strobes.
module vtg_1080p #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ce,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] x,
    output logic [10:0] y,
    output logic        line_start,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Last h count of each horizontal phase; the phase FSM steps when h sits on one of these.
    localparam logic [11:0] H_END_ACT  = 12'(H_ACTIVE - 1);
    localparam logic [11:0] H_END_FP   = 12'(H_ACTIVE + H_FP - 1);
    localparam logic [11:0] H_END_SYNC = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] H_END      = 12'(H_TOTAL - 1);

    localparam logic [10:0] V_ACT_LINES = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_END       = 11'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        H_ST_ACTIVE,
        H_ST_FP,
        H_ST_SYNC,
        H_ST_BP
    } h_phase_t;

    h_phase_t    r_phase;
    logic [11:0] r_h;
    logic [10:0] r_v;
    logic        r_de;
    logic        r_hsync;
    logic        r_vsync;
    logic [11:0] r_x;
    logic [10:0] r_y;
    logic        r_line_start;
    logic        r_frame_start;

    logic        w_h_active;
    logic        w_v_active;
    logic        w_v_sync;

    assign w_h_active = (r_phase == H_ST_ACTIVE);
    assign w_v_active = (r_v < V_ACT_LINES);
    assign w_v_sync   = (r_v >= V_SYNC_BEG) && (r_v < V_SYNC_END);

    // NOTE: rstn is sampled inside the clocked branch (synchronous) and overrides ce, so a
    // mid-frame reset lands on the very next posedge whether or not a pixel is advancing.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_phase       <= H_ST_ACTIVE;
            r_h           <= '0;
            r_v           <= '0;
            r_de          <= 1'b0;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;

            if (ce) begin
                r_de          <= w_h_active && w_v_active;
                r_hsync       <= (r_phase == H_ST_SYNC) ? HS_POL : ~HS_POL;
                r_vsync       <= w_v_sync ? VS_POL : ~VS_POL;
                r_line_start  <= (r_h == '0) && w_v_active;
                r_frame_start <= (r_h == '0) && (r_v == '0);

                if (w_h_active && w_v_active) begin
                    r_x <= r_h;
                    r_y <= r_v;
                end

                if (r_h == H_END) begin
                    r_h <= '0;
                    r_v <= (r_v == V_END) ? '0 : r_v + 11'd1;
                end else begin
                    r_h <= r_h + 12'd1;
                end

                case (r_phase)
                    H_ST_ACTIVE: if (r_h == H_END_ACT)  r_phase <= H_ST_FP;
                    H_ST_FP:     if (r_h == H_END_FP)   r_phase <= H_ST_SYNC;
                    H_ST_SYNC:   if (r_h == H_END_SYNC) r_phase <= H_ST_BP;
                    H_ST_BP:     if (r_h == H_END)      r_phase <= H_ST_ACTIVE;
                    default:                            r_phase <= H_ST_ACTIVE;
                endcase
            end
        end
    end

    assign de          = r_de;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
